bkram_sd_ctrl: RTL and testbench

//  Parametrised backup-RAM <-> SD image sector sequencer for the emu top. It

---
 rtl/bkram_pkg.sv | 20 ++
 rtl/bkram_sd_ctrl_if.sv | 12 +
 rtl/bkram_sd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_bkram_sd_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bkram_pkg.sv
// Shared types and constants for the backup-RAM <-> SD sector sequencer.
// HDR is the default format header that the top's port-B mux writes at fmt_idx.
package bkram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_FORMAT
    } state_t;

    localparam int HDR_WORDS = 4;
    localparam logic [15:0] HDR [HDR_WORDS] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

    function automatic logic [15:0] hdr_word(input int unsigned idx);
        return HDR[idx % HDR_WORDS];
    endfunction

endpackage

// File: rtl/bkram_sd_ctrl_if.sv
// hps_io sector handshake: the sequencer is master (lba/rd/wr), hps_io is slave (ack).
interface bkram_sd_ctrl_if;

    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    modport master (output sd_lba, sd_rd, sd_wr, input  sd_ack);
    modport slave  (input  sd_lba, sd_rd, sd_wr, output sd_ack);

endinterface

// File: rtl/bkram_sd_ctrl.sv
// Backup-RAM save-slot sequencer: streams SECTORS sectors per slot through hps_io,
// runs deferred format on port B, tracks dirty state and triggers idle autosave.
module bkram_sd_ctrl
    import bkram_pkg::*;
#(
    parameter  int SECTORS   = 16,
    parameter  int SLOTS     = 4,
    parameter  int FMT_WORDS = 4,
    parameter  int AUTOSAVE  = 0,
    localparam int SB  = (SECTORS   > 1) ? $clog2(SECTORS)    : 1,
    localparam int SLB = (SLOTS     > 1) ? $clog2(SLOTS)      : 1,
    localparam int FW  = (FMT_WORDS > 1) ? $clog2(FMT_WORDS)  : 1,
    localparam int IW  = (AUTOSAVE  > 0) ? $clog2(AUTOSAVE+1) : 1
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            download,
    input  logic            img_mounted,
    input  logic            img_ok,
    input  logic            load_req,
    input  logic            save_req,
    input  logic            format_req,
    input  logic [SLB-1:0]  slot,
    input  logic            bram_dirty,
    bkram_sd_ctrl_if.master sd,
    output logic            ena,
    output logic            busy,
    output logic            hold_reset,
    output logic            fmt_active,
    output logic            fmt_we,
    output logic [FW-1:0]   fmt_idx
);

    state_t          state, state_nx;
    logic            load_q, save_q, fmt_q, dl_q, ack_q;
    logic [SLB-1:0]  slot_q;
    logic [SB-1:0]   sector;
    logic            loading, dirty, pending_fmt;
    logic [IW-1:0]   idle_cnt;

    logic load_edge, save_edge, fmt_edge, ack_rise, ack_fall;
    logic xfer_ok, autosave_hit, last_sector, fmt_last;
    logic start_fmt, start_load, start_save, xfer_end;

    assign load_edge = load_req   & ~load_q;
    assign save_edge = save_req   & ~save_q;
    assign fmt_edge  = format_req & ~fmt_q;
    assign ack_rise  = sd.sd_ack  & ~ack_q;
    assign ack_fall  = ~sd.sd_ack & ack_q;

    // Requiring ack low also covers the post-reset case where hps_io is mid-sector.
    assign xfer_ok      = ena & ~sd.sd_ack;
    assign autosave_hit = (AUTOSAVE != 0) && (idle_cnt == IW'(AUTOSAVE));
    assign last_sector  = (sector  == SB'(SECTORS - 1));
    assign fmt_last     = (fmt_idx == FW'(FMT_WORDS - 1));

    assign start_fmt  = (state == ST_IDLE) && pending_fmt;
    assign start_load = (state == ST_IDLE) && !pending_fmt && load_edge && xfer_ok;
    assign start_save = (state == ST_IDLE) && !pending_fmt && !load_edge && xfer_ok
                        && (save_edge || autosave_hit);
    assign xfer_end   = (state == ST_WAIT_LO) && ack_fall && last_sector;

    assign sd.sd_lba = 32'({slot_q, sector});

    always_ff @(posedge clk_sys) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:    if (start_fmt)                    state_nx = ST_FORMAT;
                        else if (start_load || start_save) state_nx = ST_ISSUE;
            ST_ISSUE:   state_nx = ST_WAIT_HI;
            ST_WAIT_HI: if (ack_rise) state_nx = ST_WAIT_LO;
            ST_WAIT_LO: if (ack_fall) state_nx = last_sector ? ST_IDLE : ST_ISSUE;
            ST_FORMAT:  if (fmt_last) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        sd.sd_rd   = 1'b0;
        sd.sd_wr   = 1'b0;
        busy       = 1'b1;
        fmt_active = 1'b0;
        fmt_we     = 1'b0;
        unique case (state)
            ST_IDLE: busy = 1'b0;
            ST_ISSUE, ST_WAIT_HI: begin
                sd.sd_rd = loading;
                sd.sd_wr = ~loading;
            end
            ST_FORMAT: begin
                fmt_active = 1'b1;
                fmt_we     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            load_q      <= 1'b0;
            save_q      <= 1'b0;
            fmt_q       <= 1'b0;
            dl_q        <= 1'b0;
            ack_q       <= 1'b0;
            ena         <= 1'b0;
            slot_q      <= '0;
            sector      <= '0;
            loading     <= 1'b0;
            hold_reset  <= 1'b0;
            dirty       <= 1'b0;
            pending_fmt <= 1'b0;
            fmt_idx     <= '0;
            idle_cnt    <= '0;
        end else begin
            load_q <= load_req;
            save_q <= save_req;
            fmt_q  <= format_req;
            dl_q   <= download;
            ack_q  <= sd.sd_ack;

            if (download && !dl_q)                   ena <= 1'b0;
            if (download && img_mounted && img_ok)   ena <= 1'b1;

            // Every edge seen before the format actually starts folds into one run.
            if (start_fmt)     pending_fmt <= 1'b0;
            else if (fmt_edge) pending_fmt <= 1'b1;

            if (start_load || start_save) begin
                sector     <= '0;
                loading    <= start_load;
                hold_reset <= start_load;
                if (start_load || save_edge) slot_q <= slot;
            end

            if (state == ST_WAIT_LO && ack_fall) begin
                if (last_sector) hold_reset <= 1'b0;
                else             sector     <= sector + 1'b1;
            end

            if (state == ST_FORMAT) fmt_idx <= fmt_last ? '0 : fmt_idx + 1'b1;

            // A core write in the same cycle always wins over a clear.
            if (bram_dirty)                         dirty <= 1'b1;
            else if (state == ST_FORMAT && fmt_last) dirty <= 1'b1;
            else if (start_save)                     dirty <= 1'b0;
            else if (xfer_end && loading)            dirty <= 1'b0;

            if (bram_dirty || !dirty)
                idle_cnt <= '0;
            else if (state == ST_IDLE && idle_cnt != IW'(AUTOSAVE))
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bkram_sd_ctrl.sv
// Directed bench for bkram_sd_ctrl: table of slot transfers plus hand sequences
// for deferred format, autosave timing and reset in the middle of a sector.
module tb_bkram_sd_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, download, img_mounted, img_ok;
    logic       load_req, save_req, format_req, bram_dirty;
    logic [1:0] slot;
    logic       ena, busy, hold_reset, fmt_active, fmt_we;
    logic [1:0] fmt_idx;

    bkram_sd_ctrl_if sdi();

    bkram_sd_ctrl #(.AUTOSAVE(100)) dut (
        .clk_sys    (clk),
        .reset_n    (reset_n),
        .download   (download),
        .img_mounted(img_mounted),
        .img_ok     (img_ok),
        .load_req   (load_req),
        .save_req   (save_req),
        .format_req (format_req),
        .slot       (slot),
        .bram_dirty (bram_dirty),
        .sd         (sdi),
        .ena        (ena),
        .busy       (busy),
        .hold_reset (hold_reset),
        .fmt_active (fmt_active),
        .fmt_we     (fmt_we),
        .fmt_idx    (fmt_idx)
    );

    int n_vec = 0;
    int n_err = 0;

    // hps_io model: ack rises 2 negedges after rd/wr is seen, stays high 3 negedges.
    logic        ack_force = 1'b0;
    int          rsp_t = 0;
    int          nsec = 0;
    logic [31:0] lba_log [256];
    logic        rd_log  [256];
    logic        wr_log  [256];

    initial begin
        sdi.sd_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_force) begin
                sdi.sd_ack = 1'b1;
                rsp_t = 0;
            end else if (rsp_t != 0) begin
                rsp_t++;
                if (rsp_t == 3) begin
                    sdi.sd_ack = 1'b1;
                    lba_log[nsec % 256] = sdi.sd_lba;
                    rd_log[nsec % 256]  = sdi.sd_rd;
                    wr_log[nsec % 256]  = sdi.sd_wr;
                    nsec++;
                end
                if (rsp_t == 6) begin
                    sdi.sd_ack = 1'b0;
                    rsp_t = 0;
                end
            end else begin
                sdi.sd_ack = 1'b0;
                if (sdi.sd_rd || sdi.sd_wr) rsp_t = 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int k;
        k = 0;
        while (busy && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(nm, busy, 0);
    endtask

    task automatic mount();
        download = 1'b1; img_ok = 1'b1; img_mounted = 1'b1;
        @(negedge clk);
        img_mounted = 1'b0;
        @(negedge clk);
    endtask

    // kind: 0 = save, 1 = load, 2 = load and save rising together
    typedef struct {
        int          kind;
        logic [1:0]  slot;
        logic [31:0] base;
        logic        exp_rd;
    } vec_t;

    task automatic run_xfer(input vec_t v, input int id);
        int n0, hbad, k;
        n0 = nsec; hbad = 0; k = 0;
        slot     = v.slot;
        load_req = (v.kind != 0);
        save_req = (v.kind != 1);
        @(negedge clk);
        load_req = 1'b0; save_req = 1'b0;
        slot = ~v.slot;   // slot must already be latched
        chk($sformatf("v%0d_busy_start", id), busy, 1);
        while (busy && k < 600) begin
            if (hold_reset !== v.exp_rd) hbad++;
            @(negedge clk);
            k++;
        end
        chk($sformatf("v%0d_done", id), busy, 0);
        chk($sformatf("v%0d_hold_during", id), hbad, 0);
        chk($sformatf("v%0d_hold_after", id), hold_reset, 0);
        chk($sformatf("v%0d_sectors", id), nsec - n0, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("v%0d_lba%0d", id, i), lba_log[(n0 + i) % 256], v.base + i);
            chk($sformatf("v%0d_rd%0d", id, i), rd_log[(n0 + i) % 256], v.exp_rd);
            chk($sformatf("v%0d_wr%0d", id, i), wr_log[(n0 + i) % 256], !v.exp_rd);
        end
        cyc(10);
        chk($sformatf("v%0d_no_followup", id), busy, 0);
        chk($sformatf("v%0d_no_extra_sec", id), nsec - n0, 16);
    endtask

    vec_t tv [5];

    initial begin
        int n0, k, fcnt, fbad, first, last, sec_at_fmt, t6n;
        logic [1:0] fidx [4];

        tv[0] = '{0, 2'd2, 32'h20, 1'b0};
        tv[1] = '{1, 2'd3, 32'h30, 1'b1};
        tv[2] = '{2, 2'd1, 32'h10, 1'b1};
        tv[3] = '{0, 2'd0, 32'h00, 1'b0};
        tv[4] = '{1, 2'd2, 32'h20, 1'b1};

        reset_n = 1'b0; download = 1'b0; img_mounted = 1'b0; img_ok = 1'b0;
        load_req = 1'b0; save_req = 1'b0; format_req = 1'b0; bram_dirty = 1'b0;
        slot = 2'd0;
        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_rd", sdi.sd_rd, 0);
        chk("rst_wr", sdi.sd_wr, 0);
        chk("rst_lba", sdi.sd_lba, 0);
        chk("rst_hold", hold_reset, 0);
        chk("rst_fmt", {fmt_active, fmt_we, fmt_idx}, 0);
        chk("rst_ena", ena, 0);
        reset_n = 1'b1;
        cyc(2);

        // No image mounted: a save edge must be ignored.
        save_req = 1'b1; cyc(1); save_req = 1'b0; cyc(4);
        chk("noena_ignored", busy, 0);

        mount();
        chk("ena_set", ena, 1);

        for (int i = 0; i < 5; i++) run_xfer(tv[i], i);

        // Format requested during sector 5 of a save runs after the save.
        n0 = nsec; k = 0;
        slot = 2'd1; save_req = 1'b1; cyc(1); save_req = 1'b0;
        while (!(busy && sdi.sd_lba == 32'h15) && k < 300) begin cyc(1); k++; end
        chk("t4_at_sector5", sdi.sd_lba, 32'h15);
        format_req = 1'b1; cyc(1); format_req = 1'b0;
        fcnt = 0; fbad = 0; first = -1; last = -1; sec_at_fmt = -1; k = 0;
        while (k < 800) begin
            cyc(1); k++;
            if (fmt_active !== fmt_we) fbad++;
            if (fmt_we) begin
                if (fcnt < 4) fidx[fcnt] = fmt_idx;
                if (first < 0) begin first = k; sec_at_fmt = nsec - n0; end
                last = k;
                fcnt++;
            end else if (fcnt != 0) break;
        end
        chk("t4_fmt_cycles", fcnt, 4);
        chk("t4_fmt_contig", last - first, 3);
        chk("t4_save_first", sec_at_fmt, 16);
        chk("t4_active_eq_we", fbad, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("t4_idx%0d", i), fidx[i], i);
        // dirty was set by the format: autosave of slot 1 after 100 idle cycles
        cyc(100);
        chk("t4_autosave_early", busy, 0);
        cyc(1);
        chk("t4_autosave_busy", busy, 1);
        chk("t4_autosave_wr", sdi.sd_wr, 1);
        chk("t4_autosave_lba", sdi.sd_lba, 32'h10);
        wait_idle("t4_autosave_done", 600);
        cyc(5);

        // One dirty pulse: save starts on the 101st edge after the sampling edge.
        bram_dirty = 1'b1; cyc(1); bram_dirty = 1'b0;
        cyc(100);
        chk("t5_not_yet", busy, 0);
        cyc(1);
        chk("t5_started", busy, 1);
        chk("t5_is_write", sdi.sd_wr, 1);
        wait_idle("t5_done", 600);
        cyc(5);

        // Second pulse 50 cycles in restarts the idle count.
        bram_dirty = 1'b1; cyc(1); bram_dirty = 1'b0;
        cyc(49);
        bram_dirty = 1'b1; cyc(1); bram_dirty = 1'b0;
        cyc(50);
        chk("t5r_old_deadline", busy, 0);
        cyc(50);
        chk("t5r_not_yet", busy, 0);
        cyc(1);
        chk("t5r_started", busy, 1);
        wait_idle("t5r_done", 600);
        cyc(5);

        // Reset while waiting for ack; hps_io keeps ack high across it.
        slot = 2'd2; save_req = 1'b1; cyc(1); save_req = 1'b0;
        chk("t6_issue_wr", sdi.sd_wr, 1);
        cyc(1);
        chk("t6_wait_busy", busy, 1);
        reset_n = 1'b0; ack_force = 1'b1;
        cyc(1);
        chk("t6_rd", sdi.sd_rd, 0);
        chk("t6_wr", sdi.sd_wr, 0);
        chk("t6_busy", busy, 0);
        chk("t6_hold", hold_reset, 0);
        reset_n = 1'b1;
        cyc(2);
        mount();
        chk("t6_ena", ena, 1);
        chk("t6_ack_high", sdi.sd_ack, 1);
        save_req = 1'b1; cyc(1); save_req = 1'b0; cyc(5);
        chk("t6_ack_blocks", busy, 0);
        ack_force = 1'b0;
        cyc(3);
        t6n = nsec;
        save_req = 1'b1; cyc(1); save_req = 1'b0;
        chk("t6_accept", busy, 1);
        wait_idle("t6_done", 600);
        chk("t6_sectors", nsec - t6n, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
